// File: rtl/hazard_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_fwd_scoreboard
//
// Data-hazard and forwarding unit for the PA-RISC pipeline. Each of the
// NUM_SRC source operands of the instruction in ID is compared against the
// destination register of NUM_FWD downstream stages, from EX (stage 0) to the
// oldest stage (NUM_FWD-1). The youngest matching stage supplies the operand.
// A load in EX that feeds an operand in ID is a load-use hazard. The unit
// holds ID and injects exactly LOAD_LAT bubbles into EX, after which the load
// result is reachable by forwarding from stage LOAD_LAT. GR0 is hardwired to
// zero, so it never forwards and never stalls. A flush aborts any stall in
// progress. Bubble cycles are counted in a saturating 16-bit counter.
//
// Parameters
//   NUM_SRC   source operands checked per ID instruction
//   NUM_FWD   forwarding stages (EX, MEM, WB, ...)
//   AW        register address width
//   LOAD_LAT  bubbles per load-use event (1..NUM_FWD-1, at most 3)
//   SELW      width of one forwarding select field
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   src_reg       source register addresses, operand i at [i*AW +: AW]
//   src_used      operand i is read by the instruction in ID
//   stage_rd      destination register per stage, stage s at [s*AW +: AW]
//   stage_we      register-file write enable per stage
//   ex_is_load    instruction in EX is a load
//   flush         pipeline redirect, aborts any stall
//   fwd_sel       per operand: 0 = register file, s+1 = forward from stage s
//   nop           inject a bubble into EX this cycle
//   id_le         IF/ID load enable, always !nop
//   stall_cycles  saturating count of cycles with nop=1
// ---------------------------------------------------------------------------
module hazard_fwd_scoreboard #(
   parameter int NUM_SRC  = 2,
   parameter int NUM_FWD  = 3,
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int SELW     = $clog2(NUM_FWD + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SRC*AW-1:0]   src_reg,
   input  logic [NUM_SRC-1:0]      src_used,
   input  logic [NUM_FWD*AW-1:0]   stage_rd,
   input  logic [NUM_FWD-1:0]      stage_we,
   input  logic                    ex_is_load,
   input  logic                    flush,
   output logic [NUM_SRC*SELW-1:0] fwd_sel,
   output logic                    nop,
   output logic                    id_le,
   output logic [15:0]             stall_cycles
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Value of cnt on the last WAIT cycle of a stall.
   localparam logic [1:0] LAST_CNT = 2'(LOAD_LAT - 1);
   localparam logic       MULTI_BUBBLE = (LOAD_LAT > 1);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] stall_q, stall_d;

   logic [NUM_SRC-1:0][NUM_FWD-1:0] match;
   logic                            load_use;
   logic                            nop_raw;

   // ------------------------------------------------------------------
   // Operand / stage comparison matrix. GR0 is excluded here so it can
   // neither forward nor raise a stall anywhere downstream.
   // ------------------------------------------------------------------
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int s = 0; s < NUM_FWD; s++) begin
            match[i][s] = src_used[i] && stage_we[s] &&
                          (src_reg[i*AW +: AW] == stage_rd[s*AW +: AW]) &&
                          (src_reg[i*AW +: AW] != '0);
         end
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         load_use = load_use | match[i][0];
      end
      load_use = load_use & ex_is_load;
   end

   // ------------------------------------------------------------------
   // Forwarding selects. Scanning from the oldest stage down lets the
   // youngest matching stage overwrite older ones, so it wins.
   // ------------------------------------------------------------------
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (match[i][s]) begin
               fwd_sel[i*SELW +: SELW] = SELW'(s + 1);
            end
         end
      end
      if (!rst_n) begin
         fwd_sel = '0;
      end
   end

   // ------------------------------------------------------------------
   // Stall state machine. The IDLE cycle that detects the hazard is the
   // first bubble; WAIT supplies the remaining LOAD_LAT-1. While in WAIT
   // EX holds a bubble, so load_use is deliberately ignored there.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nop_raw = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_use) begin
                  nop_raw = 1'b1;
                  if (MULTI_BUBBLE) begin
                     state_d = ST_WAIT;
                     cnt_d   = 2'd1;
                  end
               end
            end
            ST_WAIT: begin
               nop_raw = 1'b1;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_IDLE;
                  cnt_d   = 2'd0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   // Outputs are forced to their idle values for as long as reset is held,
   // independent of any clock edge.
   always_comb begin
      nop   = nop_raw & rst_n;
      id_le = ~nop;
   end

   // Saturating bubble counter; it sticks at all-ones instead of wrapping.
   always_comb begin
      stall_d = stall_q;
      if (nop && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         stall_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_scoreboard
//
// Directed bench for hazard_fwd_scoreboard. Three instances share clk/rst_n:
//   u1: NUM_FWD=3, LOAD_LAT=1
//   u2: NUM_FWD=4, LOAD_LAT=2
//   u3: NUM_FWD=4, LOAD_LAT=3
// Inputs change #1 after a rising edge; combinational outputs are checked
// #1 later and registered outputs #1 after the following edge.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_scoreboard;

   logic clk;
   logic rst_n;

   // u1 signals (NUM_FWD=3, SELW=2)
   logic [9:0]  s1_src_reg;
   logic [1:0]  s1_src_used;
   logic [14:0] s1_stage_rd;
   logic [2:0]  s1_stage_we;
   logic        s1_load, s1_flush;
   logic [3:0]  s1_fwd;
   logic        s1_nop, s1_idle;
   logic [15:0] s1_stall;

   // u2 signals (NUM_FWD=4, SELW=3)
   logic [9:0]  s2_src_reg;
   logic [1:0]  s2_src_used;
   logic [19:0] s2_stage_rd;
   logic [3:0]  s2_stage_we;
   logic        s2_load, s2_flush;
   logic [5:0]  s2_fwd;
   logic        s2_nop, s2_idle;
   logic [15:0] s2_stall;

   // u3 signals (NUM_FWD=4, SELW=3)
   logic [9:0]  s3_src_reg;
   logic [1:0]  s3_src_used;
   logic [19:0] s3_stage_rd;
   logic [3:0]  s3_stage_we;
   logic        s3_load, s3_flush;
   logic [5:0]  s3_fwd;
   logic        s3_nop, s3_idle;
   logic [15:0] s3_stall;

   int errors;
   int checks;

   hazard_fwd_scoreboard #(.NUM_SRC(2), .NUM_FWD(3), .AW(5), .LOAD_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .src_reg(s1_src_reg), .src_used(s1_src_used),
      .stage_rd(s1_stage_rd), .stage_we(s1_stage_we),
      .ex_is_load(s1_load), .flush(s1_flush),
      .fwd_sel(s1_fwd), .nop(s1_nop), .id_le(s1_idle), .stall_cycles(s1_stall)
   );

   hazard_fwd_scoreboard #(.NUM_SRC(2), .NUM_FWD(4), .AW(5), .LOAD_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n),
      .src_reg(s2_src_reg), .src_used(s2_src_used),
      .stage_rd(s2_stage_rd), .stage_we(s2_stage_we),
      .ex_is_load(s2_load), .flush(s2_flush),
      .fwd_sel(s2_fwd), .nop(s2_nop), .id_le(s2_idle), .stall_cycles(s2_stall)
   );

   hazard_fwd_scoreboard #(.NUM_SRC(2), .NUM_FWD(4), .AW(5), .LOAD_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .src_reg(s3_src_reg), .src_used(s3_src_used),
      .stage_rd(s3_stage_rd), .stage_we(s3_stage_we),
      .ex_is_load(s3_load), .flush(s3_flush),
      .fwd_sel(s3_fwd), .nop(s3_nop), .id_le(s3_idle), .stall_cycles(s3_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Advance to #1 after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      s1_src_reg = '0; s1_src_used = '0; s1_stage_rd = '0; s1_stage_we = '0;
      s1_load = 1'b0;  s1_flush = 1'b0;
      s2_src_reg = '0; s2_src_used = '0; s2_stage_rd = '0; s2_stage_we = '0;
      s2_load = 1'b0;  s2_flush = 1'b0;
      s3_src_reg = '0; s3_src_used = '0; s3_stage_rd = '0; s3_stage_we = '0;
      s3_load = 1'b0;  s3_flush = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      clear_inputs();

      // Reset with a live load-use hazard on u1: outputs must stay forced.
      s1_src_reg = {5'd0, 5'd5}; s1_src_used = 2'b01;
      s1_stage_rd = {5'd0, 5'd0, 5'd5}; s1_stage_we = 3'b001; s1_load = 1'b1;
      #2;
      chk("rst_nop",   32'(s1_nop), 32'd0);
      chk("rst_id_le", 32'(s1_idle), 32'd1);
      chk("rst_fwd",   32'(s1_fwd), 32'd0);
      cyc(); cyc();
      chk("rst_stall", 32'(s1_stall), 32'd0);
      clear_inputs();
      rst_n = 1'b1;
      #1;
      chk("post_rst_nop", 32'(s1_nop), 32'd0);

      // Forwarding priority: r5 in every stage, youngest wins.
      cyc();
      s1_src_reg = {5'd0, 5'd5}; s1_src_used = 2'b01;
      s1_stage_rd = {5'd5, 5'd5, 5'd5}; s1_stage_we = 3'b111;
      #1;
      chk("fwd0_ex",   32'(s1_fwd[1:0]), 32'd1);
      chk("fwd1_unused", 32'(s1_fwd[3:2]), 32'd0);
      chk("fwd_nop",   32'(s1_nop), 32'd0);
      s1_stage_we = 3'b110;
      #1;
      chk("fwd0_mem",  32'(s1_fwd[1:0]), 32'd2);
      s1_stage_we = 3'b100;
      #1;
      chk("fwd0_wb",   32'(s1_fwd[1:0]), 32'd3);

      // GR0 never forwards or stalls, even from a load.
      s1_src_reg = {5'd0, 5'd0}; s1_src_used = 2'b11;
      s1_stage_rd = '0; s1_stage_we = 3'b111; s1_load = 1'b1;
      #1;
      chk("gr0_fwd", 32'(s1_fwd), 32'd0);
      chk("gr0_nop", 32'(s1_nop), 32'd0);
      cyc();
      chk("gr0_stall", 32'(s1_stall), 32'd0);

      // Non-load EX producer forwards without stalling.
      s1_src_reg = {5'd7, 5'd0}; s1_src_used = 2'b10;
      s1_stage_rd = {5'd0, 5'd0, 5'd7}; s1_stage_we = 3'b001; s1_load = 1'b0;
      #1;
      chk("alu_fwd1", 32'(s1_fwd[3:2]), 32'd1);
      chk("alu_nop",  32'(s1_nop), 32'd0);

      // LOAD_LAT=1 load-use on r7 via operand 1.
      s1_load = 1'b1;
      #1;
      chk("ll1_nop",   32'(s1_nop), 32'd1);
      chk("ll1_id_le", 32'(s1_idle), 32'd0);
      cyc();
      chk("ll1_stall", 32'(s1_stall), 32'd1);
      s1_stage_rd = {5'd0, 5'd7, 5'd0}; s1_stage_we = 3'b010; s1_load = 1'b0;
      #1;
      chk("ll1_after_nop", 32'(s1_nop), 32'd0);
      chk("ll1_after_le",  32'(s1_idle), 32'd1);
      chk("ll1_after_fwd", 32'(s1_fwd[3:2]), 32'd2);
      cyc();
      chk("ll1_after_stall", 32'(s1_stall), 32'd1);

      // Two operands hit different stages; one bubble only.
      s1_src_reg = {5'd6, 5'd4}; s1_src_used = 2'b11;
      s1_stage_rd = {5'd0, 5'd4, 5'd6}; s1_stage_we = 3'b011; s1_load = 1'b1;
      #1;
      chk("multi_fwd0", 32'(s1_fwd[1:0]), 32'd2);
      chk("multi_fwd1", 32'(s1_fwd[3:2]), 32'd1);
      chk("multi_nop",  32'(s1_nop), 32'd1);
      cyc();
      chk("multi_stall", 32'(s1_stall), 32'd2);
      clear_inputs();

      // LOAD_LAT=2, NUM_FWD=4: load-use on r9 gives two bubbles.
      s2_src_reg = {5'd0, 5'd9}; s2_src_used = 2'b01;
      s2_stage_rd = {5'd0, 5'd0, 5'd0, 5'd9}; s2_stage_we = 4'b0001; s2_load = 1'b1;
      #1;
      chk("ll2_b1_nop", 32'(s2_nop), 32'd1);
      cyc();
      chk("ll2_b1_stall", 32'(s2_stall), 32'd1);
      s2_stage_rd = {5'd0, 5'd0, 5'd9, 5'd0}; s2_stage_we = 4'b0010; s2_load = 1'b0;
      #1;
      chk("ll2_b2_nop", 32'(s2_nop), 32'd1);
      chk("ll2_b2_le",  32'(s2_idle), 32'd0);
      cyc();
      chk("ll2_b2_stall", 32'(s2_stall), 32'd2);
      s2_stage_rd = {5'd0, 5'd9, 5'd0, 5'd0}; s2_stage_we = 4'b0100;
      #1;
      chk("ll2_done_nop", 32'(s2_nop), 32'd0);
      chk("ll2_done_fwd", 32'(s2_fwd[2:0]), 32'd3);
      cyc();
      chk("ll2_done_stall", 32'(s2_stall), 32'd2);
      clear_inputs();

      // LOAD_LAT=3: flush in the second bubble aborts the stall.
      s3_src_reg = {5'd0, 5'd9}; s3_src_used = 2'b01;
      s3_stage_rd = {5'd0, 5'd0, 5'd0, 5'd9}; s3_stage_we = 4'b0001; s3_load = 1'b1;
      #1;
      chk("fl_b1_nop", 32'(s3_nop), 32'd1);
      cyc();
      chk("fl_b1_stall", 32'(s3_stall), 32'd1);
      s3_stage_rd = {5'd0, 5'd0, 5'd9, 5'd0}; s3_stage_we = 4'b0010; s3_load = 1'b0;
      s3_flush = 1'b1;
      #1;
      chk("fl_flush_nop", 32'(s3_nop), 32'd0);
      chk("fl_flush_le",  32'(s3_idle), 32'd1);
      cyc();
      chk("fl_flush_stall", 32'(s3_stall), 32'd1);
      clear_inputs();
      #1;
      chk("fl_after_nop", 32'(s3_nop), 32'd0);
      cyc();
      chk("fl_after2_nop", 32'(s3_nop), 32'd0);
      chk("fl_after_stall", 32'(s3_stall), 32'd1);

      // Asynchronous reset in the middle of a WAIT.
      s3_src_reg = {5'd0, 5'd9}; s3_src_used = 2'b01;
      s3_stage_rd = {5'd0, 5'd0, 5'd0, 5'd9}; s3_stage_we = 4'b0001; s3_load = 1'b1;
      cyc();
      s3_stage_rd = {5'd0, 5'd0, 5'd9, 5'd0}; s3_stage_we = 4'b0010; s3_load = 1'b0;
      #1;
      chk("ar_wait_nop", 32'(s3_nop), 32'd1);
      chk("ar_wait_fwd", 32'(s3_fwd[2:0]), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("ar_nop",   32'(s3_nop), 32'd0);
      chk("ar_id_le", 32'(s3_idle), 32'd1);
      chk("ar_fwd",   32'(s3_fwd), 32'd0);
      chk("ar_stall", 32'(s3_stall), 32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("ar_rel_nop", 32'(s3_nop), 32'd0);
      chk("ar_rel_fwd", 32'(s3_fwd[2:0]), 32'd2);
      cyc();
      chk("ar_idle_nop",   32'(s3_nop), 32'd0);
      chk("ar_idle_stall", 32'(s3_stall), 32'd0);

      // Back-to-back load-use keeps nop high; counter must saturate.
      s3_stage_rd = {5'd0, 5'd0, 5'd0, 5'd9}; s3_stage_we = 4'b0001; s3_load = 1'b1;
      #1;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", 32'(s3_stall), 32'h0000FFFE);
      chk("sat_nop",  32'(s3_nop), 32'd1);
      cyc();
      chk("sat_ffff", 32'(s3_stall), 32'h0000FFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("sat_hold", 32'(s3_stall), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_scoreboard.md
Name: hazard_fwd_scoreboard

Overview:
Parametrised data-hazard and forwarding unit for the PA-RISC pipeline. It serves NUM_SRC source operands against NUM_FWD destination stages, from EX (index 0) to the oldest stage (index NUM_FWD-1). It is a sequential replacement for the single-cycle load-use stall: a state machine holds ID and injects bubbles for LOAD_LAT cycles. It also treats GR0 as hardwired zero, supports flush abort and counts stall cycles for performance monitoring.

Parameters:
NUM_SRC, 2, number of source operands checked per instruction in ID.
NUM_FWD, 3, number of forwarding stages (EX, MEM, WB).
AW, 5, register address width.
LOAD_LAT, 1, number of bubble cycles required before load data can be forwarded (legal 1..NUM_FWD-1).
SELW, clog2(NUM_FWD+1), width of each forwarding select field.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
src_reg  in  NUM_SRC*AW  source register addresses; operand i occupies bits [i*AW +: AW].
src_used  in  NUM_SRC  operand i is actually read by the instruction in ID.
stage_rd  in  NUM_FWD*AW  destination register per stage; stage s occupies bits [s*AW +: AW].
stage_we  in  NUM_FWD  register-file write enable per stage.
ex_is_load  in  1  instruction in EX is a load.
flush  in  1  pipeline redirect; aborts any stall.
fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, s+1 = forward from stage s.
nop  out  1  inject a bubble into EX this cycle.
id_le  out  1  IF/ID load enable; always equal to !nop.
stall_cycles  out  16  saturating count of cycles with nop=1.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE, cnt=0, stall_cycles=0. While rst_n is low, outputs are forced to nop=0, id_le=1, fwd_sel=0.
- Match(i,s) is true when src_used[i], stage_we[s], src_reg[i]==stage_rd[s] and src_reg[i]!=0. GR0 never forwards and never stalls.
- fwd_sel[i] is combinational: the lowest s with Match(i,s) gives s+1 (youngest stage wins); no match gives 0. It is evaluated every cycle and consumed only when nop=0.
- load_use is true when ex_is_load and Match(i,0) holds for any i.
- State machine has two states, IDLE and WAIT. cnt is 2 bits wide, sized for LOAD_LAT up to 3.
- IDLE, load_use and !flush: nop=1 combinationally in the same cycle. If LOAD_LAT>1, go to WAIT with cnt<=1; if LOAD_LAT==1, stay in IDLE (single bubble).
- IDLE otherwise: nop=0.
- WAIT: nop=1. cnt<=cnt+1. When cnt==LOAD_LAT-1, return to IDLE, so the next cycle has nop=0 unless a new hazard is detected. load_use is not re-evaluated in WAIT because EX holds a bubble.
- flush has priority in every state: nop=0 that cycle, state<=IDLE, cnt<=0.
- Total bubbles per load-use event equal LOAD_LAT exactly. On the first cycle after the stall, the held consumer's fwd_sel points to stage LOAD_LAT, where the load now resides.
- stall_cycles increments on every clk edge where nop=1 and rst_n=1. It saturates at 16'hFFFF and never wraps.
- A non-load EX producer never stalls; it only forwards (fwd_sel=1).
- If several operands hit, each operand resolves its forwarding independently; a stall is raised once.

Test Plan:
- NUM_SRC=2, NUM_FWD=3, LOAD_LAT=1. src0=r5 used; stage_rd={r5,r5,r5} all we=1; no load -> fwd_sel0=1 (EX wins). Clear stage0 we -> fwd_sel0=2. src=r0 with every stage writing r0 -> fwd_sel0=0, nop=0.
- LOAD_LAT=1: ex_is_load=1, stage_rd[0]=r7, src1=r7 -> nop=1, id_le=0 for exactly 1 cycle. Next cycle, with the load moved to MEM (stage_rd[1]=r7, ex_is_load=0) -> nop=0, fwd_sel1=2. stall_cycles=1.
- LOAD_LAT=2, NUM_FWD=4: load-use on r9 -> nop=1 for 2 consecutive cycles. Then nop=0 and fwd_sel=3. stall_cycles=2.
- LOAD_LAT=3: load-use, then flush=1 in the second stall cycle -> nop=0 that cycle, state returns to IDLE, and no further bubbles follow. stall_cycles=1.
- Drop rst_n mid-WAIT -> nop=0, id_le=1, fwd_sel=0 and stall_cycles=0 immediately, without waiting for a clock edge. After release, state is IDLE.
- Preload stall_cycles near 16'hFFFF by holding repeated load-use hazards (LOAD_LAT=3 back-to-back) -> the counter reaches 16'hFFFF and holds.
